// File: rtl/gp_block_serial_adder.sv
// gp_block_serial_adder
// Serial adder/subtractor built on per-bit generate/propagate. It processes
// one BLOCK-bit slice per clock, LSB slice first, and keeps the inter-slice
// carry in a register. It returns the sum, carry-out, signed overflow, a zero
// flag, and the word-level group generate/propagate.
//
// Ports
//   clk_i     rising-edge clock
//   rst_i     synchronous, active-high reset
//   start_i   operation request; sampled only in IDLE/DONE
//   sub_i     0: a+b+cin, 1: a-b (b inverted, carry-in forced to 1)
//   a_i, b_i  WIDTH-bit operands
//   cin_i     carry-in for add mode
//   busy_o    high while slices are being processed
//   done_o    one-cycle pulse when the result outputs update
//   sum_o     WIDTH-bit result
//   cout_o    carry out of the MSB (1 = no borrow in sub mode)
//   ovf_o     signed overflow
//   zero_o    sum == 0
//   g_out_o   word group generate (carry-independent)
//   p_out_o   word group propagate (AND of all bit propagates)
module gp_block_serial_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             g_out_o,
  output logic             p_out_o
);

  localparam int unsigned NBLK = WIDTH / BLOCK;
  localparam int unsigned IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;

  if ((BLOCK == 0) || (BLOCK > WIDTH) || ((WIDTH % BLOCK) != 0)) begin : g_bad_params
    $error("gp_block_serial_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  res_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic              gacc_q;
  logic              pacc_q;

  logic [BLOCK-1:0]       sl_sum;
  logic                   sl_cout;
  logic                   sl_cmsb;
  logic                   sl_g;
  logic                   sl_p;
  logic [WIDTH+BLOCK-1:0] res_cat;
  logic [WIDTH-1:0]       res_d;
  logic                   gacc_d;
  logic                   pacc_d;
  logic                   last_slice;

  // Ripple one slice. The low BLOCK bits of the operand shift registers hold the current slice.
  always_comb begin : slice_comb
    logic c;
    logic gi;
    logic pi;
    c       = carry_q;
    gi      = 1'b0;
    pi      = 1'b0;
    sl_sum  = '0;
    sl_g    = 1'b0;
    sl_p    = 1'b1;
    sl_cmsb = 1'b0;
    for (int i = 0; i < int'(BLOCK); i++) begin
      gi        = a_q[i] & b_q[i];
      pi        = a_q[i] ^ b_q[i];
      sl_sum[i] = pi ^ c;
      if (i == int'(BLOCK) - 1) begin
        sl_cmsb = c;
      end
      c    = gi | (pi & c);
      // Running form of OR_i(g_i & p of every higher bit in the slice).
      sl_g = gi | (pi & sl_g);
      sl_p = sl_p & pi;
    end
    sl_cout = c;
  end

  // Slice sums enter at the top of the result register, so after NBLK slices the LSB slice sits at bit 0.
  assign res_cat    = {sl_sum, res_q};
  assign res_d      = res_cat[WIDTH+BLOCK-1:BLOCK];
  assign gacc_d     = sl_g | (sl_p & gacc_q);
  assign pacc_d     = pacc_q & sl_p;
  assign last_slice = (idx_q == IDXW'(NBLK - 1));

  // Control and datapath registers. Visible outputs only change on the last slice or on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      gacc_q  <= 1'b0;
      pacc_q  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sum_o   <= '0;
      cout_o  <= 1'b0;
      ovf_o   <= 1'b0;
      zero_o  <= 1'b0;
      g_out_o <= 1'b0;
      p_out_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i | cin_i;
            res_q   <= '0;
            idx_q   <= '0;
            gacc_q  <= 1'b0;
            pacc_q  <= 1'b1;
            busy_o  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> BLOCK;
          b_q     <= b_q >> BLOCK;
          res_q   <= res_d;
          carry_q <= sl_cout;
          gacc_q  <= gacc_d;
          pacc_q  <= pacc_d;
          idx_q   <= idx_q + IDXW'(1);
          if (last_slice) begin
            sum_o   <= res_d;
            cout_o  <= sl_cout;
            ovf_o   <= sl_cmsb ^ sl_cout;
            zero_o  <= (res_d == '0);
            g_out_o <= gacc_d;
            p_out_o <= pacc_d;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gp_block_serial_adder.sv
// Testbench for gp_block_serial_adder. It runs three instances on shared
// inputs: BLOCK=8 (index 0), BLOCK=32 (index 1) and BLOCK=1 (index 2).
// Results are checked against an arithmetic reference model.
module tb_gp_block_serial_adder;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;

  logic         busy [3];
  logic         done [3];
  logic [W-1:0] sum  [3];
  logic         cout [3];
  logic         ovf  [3];
  logic         zero [3];
  logic         g    [3];
  logic         p    [3];
  logic [W+4:0] res  [3];

  int n_cmp = 0;
  int n_bad = 0;
  logic [W+4:0] last_exp0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      res[k] = {sum[k], cout[k], ovf[k], zero[k], g[k], p[k]};
    end
  end

  gp_block_serial_adder #(.WIDTH(W), .BLOCK(8)) u_b8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sub_i(sub), .a_i(a), .b_i(b), .cin_i(cin),
    .busy_o(busy[0]), .done_o(done[0]), .sum_o(sum[0]), .cout_o(cout[0]), .ovf_o(ovf[0]),
    .zero_o(zero[0]), .g_out_o(g[0]), .p_out_o(p[0]));

  gp_block_serial_adder #(.WIDTH(W), .BLOCK(32)) u_b32 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sub_i(sub), .a_i(a), .b_i(b), .cin_i(cin),
    .busy_o(busy[1]), .done_o(done[1]), .sum_o(sum[1]), .cout_o(cout[1]), .ovf_o(ovf[1]),
    .zero_o(zero[1]), .g_out_o(g[1]), .p_out_o(p[1]));

  gp_block_serial_adder #(.WIDTH(W), .BLOCK(1)) u_b1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sub_i(sub), .a_i(a), .b_i(b), .cin_i(cin),
    .busy_o(busy[2]), .done_o(done[2]), .sum_o(sum[2]), .cout_o(cout[2]), .ovf_o(ovf[2]),
    .zero_o(zero[2]), .g_out_o(g[2]), .p_out_o(p[2]));

  function automatic int nblk(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  // Reference: {sum, cout, ovf, zero, g, p} from plain wide arithmetic.
  function automatic logic [W+4:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic [W:0]   gen;
    logic         c0;
    logic         ov;
    bb   = msub ? ~mb : mb;
    c0   = msub ? 1'b1 : mcin;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c0};
    gen  = {1'b0, ma} + {1'b0, bb};
    ov   = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return {full[W-1:0], full[W], ov, (full[W-1:0] == '0), gen[W], &(ma ^ bb)};
  endfunction

  // Called at #1 after a rising edge; the start is taken at the next edge.
  task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb,
                        input logic lcin, input logic lsub);
    a = la; b = lb; cin = lcin; sub = lsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until dut k pulses done; 0 means it never did within the bound.
  task automatic wait_done(input int k, output int edges);
    edges = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (done[k]) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom); start = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if ({busy[k], done[k], res[k]} !== '0) begin
          n_bad++;
          $display("FAIL reset dut%0d cyc%0d: got busy=%b done=%b res=%h, want all 0",
                   k, c, busy[k], done[k], res[k]);
        end
      end
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap;
    int lat;
    logic [W+4:0] exp;
    exp = {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(0, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL add_wrap latency: got %0d edges, want 4", lat);
    end
    n_cmp++;
    if (res[0] !== exp) begin
      n_bad++;
      $display("FAIL add_wrap result: got %h, want %h", res[0], exp);
    end
  endtask

  task automatic test_overflow;
    int lat;
    launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(0, lat);
    n_cmp++;
    if ({sum[0], cout[0], ovf[0]} !== {32'h8000_0000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL ovf_add: got sum=%h cout=%b ovf=%b, want 80000000/0/1", sum[0], cout[0], ovf[0]);
    end
    launch(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    wait_done(0, lat);
    n_cmp++;
    if ({sum[0], cout[0], ovf[0]} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL ovf_sub: got sum=%h cout=%b ovf=%b, want 7fffffff/1/1", sum[0], cout[0], ovf[0]);
    end
  endtask

  task automatic test_full_propagate;
    int lat;
    logic [W+4:0] exp;
    exp = {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    launch(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    wait_done(0, lat);
    n_cmp++;
    if (res[0] !== exp) begin
      n_bad++;
      $display("FAIL full_propagate: got %h, want %h", res[0], exp);
    end
    last_exp0 = exp;
  endtask

  task automatic test_handshake;
    int lat;
    logic [W-1:0] a1, b1, a2, b2;
    logic [W+4:0] exp1, exp2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    exp1 = model(a1, b1, 1'b0, 1'b0);
    exp2 = model(a2, b2, 1'b1, 1'b1);
    launch(a1, b1, 1'b0, 1'b0);
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({busy[0], done[0], res[0]} !== {1'b1, 1'b0, last_exp0}) begin
        n_bad++;
        $display("FAIL run_hold e%0d: got busy=%b done=%b res=%h, want 1/0/%h",
                 e, busy[0], done[0], res[0], last_exp0);
      end
    end
    // A start pulse mid-RUN with fresh operands must be dropped.
    launch(~a1, b1 ^ 32'h1234_5678, 1'b1, 1'b1);
    wait_done(0, lat);
    n_cmp++;
    if (lat !== 1) begin
      n_bad++;
      $display("FAIL ignore_start latency: got %0d remaining edges, want 1", lat);
    end
    n_cmp++;
    if (res[0] !== exp1) begin
      n_bad++;
      $display("FAIL ignore_start result: got %h, want %h", res[0], exp1);
    end
    // Start in the done cycle is accepted.
    launch(a2, b2, 1'b1, 1'b1);
    n_cmp++;
    if ({busy[0], done[0]} !== 2'b10) begin
      n_bad++;
      $display("FAIL back_to_back accept: got busy=%b done=%b, want 1/0", busy[0], done[0]);
    end
    wait_done(0, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL back_to_back latency: got %0d edges, want 4", lat);
    end
    n_cmp++;
    if (res[0] !== exp2) begin
      n_bad++;
      $display("FAIL back_to_back result: got %h, want %h", res[0], exp2);
    end
  endtask

  // Launch n random operations on all three instances and check each result and latency.
  task automatic run_vectors(input int n, input string tag);
    logic [W-1:0] va, vb;
    logic vc, vs;
    logic [W+4:0] exp;
    bit got [3];
    for (int v = 0; v < n; v++) begin
      va = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      vb = ($urandom_range(0, 7) == 0) ? ~va : W'($urandom);
      vc = 1'($urandom);
      vs = 1'($urandom);
      exp = model(va, vb, vc, vs);
      for (int k = 0; k < 3; k++) got[k] = 1'b0;
      launch(va, vb, vc, vs);
      for (int e = 1; e <= 40; e++) begin
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
          if (done[k] && !got[k]) begin
            got[k] = 1'b1;
            n_cmp++;
            if (e !== nblk(k) || res[k] !== exp) begin
              n_bad++;
              $display("FAIL %s dut%0d vec%0d a=%h b=%h cin=%b sub=%b: got res=%h after %0d edges, want %h after %0d",
                       tag, k, v, va, vb, vc, vs, res[k], e, exp, nblk(k));
            end
          end
        end
        if (got[0] && got[1] && got[2]) break;
      end
      for (int k = 0; k < 3; k++) begin
        if (!got[k]) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s dut%0d vec%0d: no done within 40 edges, want one after %0d", tag, k, v, nblk(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    launch($urandom, $urandom, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({busy[k], done[k], res[k]} !== '0) begin
        n_bad++;
        $display("FAIL mid_reset dut%0d: got busy=%b done=%b res=%h, want all 0",
                 k, busy[k], done[k], res[k]);
      end
    end
    seen = 0;
    for (int c = 0; c < 36; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) if (done[k] || busy[k]) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL mid_reset aborted: got %0d busy/done samples after abort, want 0", seen);
    end
    run_vectors(1, "post_reset");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    last_exp0 = '0;
    test_reset();
    test_add_wrap();
    test_overflow();
    test_full_propagate();
    test_handshake();
    test_reset_mid_run();
    run_vectors(1000, "random");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
